gpmc_fifo_bridge: RTL

Synchronous slave for the Beagle GPMC muxed 16-bit address/data bus on the FX2 connector. The block sits directly behind the AD/nWE/nOE/nADV/CS4 pins and in front of fabric logic. It converts asynchronous host write cycles into pushes on a host-to-fabric FIFO, and host read cycles into pops from a fabric-to-host FIFO. It also drives the tx_data_ok/rx_data_ok flow-control lines back to the host.

---
 rtl/gpmc_fifo_bridge.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpmc_fifo_bridge.sv
// GPMC muxed 16-bit address/data slave: host writes push a host-to-fabric FIFO, host reads pop a fabric-to-host FIFO.
// Optional sticky overflow/underflow flags are enabled by defining GPMC_BRIDGE_ERR_EN.
module gpmc_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic        nWE,
  input  logic        nOE,
  input  logic        nADV,
  input  logic        CS4,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        tx_data_ok,
  output logic        rx_data_ok
);
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, WRITE, READ} state_t;
  state_t r_state, w_next;

  // Strobe bit order {CS4, nADV, nOE, nWE}; all flops idle high so reset never fakes an edge into a cycle.
  logic [3:0]  r_strb_m, r_strb_s, r_strb_d;
  logic [15:0] r_ad_m, r_ad_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strb_m <= '1;
      r_strb_s <= '1;
      r_strb_d <= '1;
      r_ad_m   <= '0;
      r_ad_s   <= '0;
    end else begin
      r_strb_m <= {CS4, nADV, nOE, nWE};
      r_strb_s <= r_strb_m;
      r_strb_d <= r_strb_s;
      r_ad_m   <= ad_in;
      r_ad_s   <= r_ad_m;
    end
  end

  logic w_cs_s, w_nadv_s, w_nwe_s;
  logic w_cs_rise, w_nadv_rise, w_noe_rise, w_noe_fall, w_nwe_rise, w_nwe_fall;
  assign w_cs_s      = r_strb_s[3];
  assign w_nadv_s    = r_strb_s[2];
  assign w_nwe_s     = r_strb_s[0];
  assign w_cs_rise   = r_strb_s[3] & ~r_strb_d[3];
  assign w_nadv_rise = r_strb_s[2] & ~r_strb_d[2];
  assign w_noe_rise  = r_strb_s[1] & ~r_strb_d[1];
  assign w_noe_fall  = ~r_strb_s[1] & r_strb_d[1];
  assign w_nwe_rise  = r_strb_s[0] & ~r_strb_d[0];
  assign w_nwe_fall  = ~r_strb_s[0] & r_strb_d[0];

  logic        r_addr, r_rd_ne;
  logic [15:0] r_wdata, r_ad_out;
  logic        r_ad_oe;
  logic        w_addr_lat, w_hpush, w_hpop, w_rd_load;

  always_comb begin
    w_next     = r_state;
    w_addr_lat = 1'b0;
    w_hpush    = 1'b0;
    w_hpop     = 1'b0;
    w_rd_load  = 1'b0;
    if (r_state != IDLE && w_cs_rise) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (!w_nadv_s && !w_cs_s) w_next = ADDR;
        ADDR:  if (w_nadv_rise) begin
                 w_next     = WAIT;
                 w_addr_lat = 1'b1;
               end
        WAIT:  if (w_nwe_fall) begin
                 w_next = WRITE;
               end else if (w_noe_fall) begin
                 w_next    = READ;
                 w_rd_load = 1'b1;
               end
        WRITE: if (w_nwe_rise) begin
                 w_next  = IDLE;
                 w_hpush = !r_addr;
               end
        READ:  if (w_noe_rise) begin
                 w_next = IDLE;
                 w_hpop = !r_addr && r_rd_ne;
               end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Write FIFO (host -> fabric)
  logic [15:0]   r_wq_mem [DEPTH];
  logic [PW-1:0] r_wq_wptr, r_wq_rptr, w_wq_wptr_n, w_wq_rptr_n, w_wq_cnt, w_wq_cnt_n;
  logic          w_wq_full, w_wq_push, w_wq_pop;
  logic [15:0]   r_wr_data;
  logic          r_wr_valid, r_tx_ok;

  assign w_wq_full   = (r_wq_wptr == {~r_wq_rptr[PW-1], r_wq_rptr[PW-2:0]});
  assign w_wq_push   = w_hpush && !w_wq_full;
  assign w_wq_pop    = r_wr_valid && wr_ready;
  assign w_wq_wptr_n = r_wq_wptr + PW'(w_wq_push);
  assign w_wq_rptr_n = r_wq_rptr + PW'(w_wq_pop);
  assign w_wq_cnt    = r_wq_wptr - r_wq_rptr;
  assign w_wq_cnt_n  = w_wq_wptr_n - w_wq_rptr_n;

  always_ff @(posedge clk) begin
    if (w_wq_push) r_wq_mem[r_wq_wptr[PW-2:0]] <= r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wq_wptr  <= '0;
      r_wq_rptr  <= '0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_tx_ok    <= 1'b0;
    end else begin
      r_wq_wptr  <= w_wq_wptr_n;
      r_wq_rptr  <= w_wq_rptr_n;
      r_wr_valid <= (w_wq_cnt_n != '0);
      r_tx_ok    <= (w_wq_cnt_n != PW'(DEPTH));
      // Bypass: a word pushed into the slot that becomes the head is not yet readable from memory.
      if (w_wq_push && (r_wq_wptr == w_wq_rptr_n)) r_wr_data <= r_wdata;
      else                                         r_wr_data <= r_wq_mem[w_wq_rptr_n[PW-2:0]];
    end
  end

  // Read FIFO (fabric -> host)
  logic [15:0]   r_rq_mem [DEPTH];
  logic [PW-1:0] r_rq_wptr, r_rq_rptr, w_rq_wptr_n, w_rq_rptr_n, w_rq_cnt;
  logic          w_rq_full, w_rq_empty, w_rq_push;
  logic          r_rx_ok;

  assign w_rq_full   = (r_rq_wptr == {~r_rq_rptr[PW-1], r_rq_rptr[PW-2:0]});
  assign w_rq_empty  = (r_rq_wptr == r_rq_rptr);
  assign w_rq_push   = rd_valid && !w_rq_full;
  assign w_rq_wptr_n = r_rq_wptr + PW'(w_rq_push);
  assign w_rq_rptr_n = r_rq_rptr + PW'(w_hpop);
  assign w_rq_cnt    = r_rq_wptr - r_rq_rptr;

  always_ff @(posedge clk) begin
    if (w_rq_push) r_rq_mem[r_rq_wptr[PW-2:0]] <= rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rq_wptr <= '0;
      r_rq_rptr <= '0;
      r_rx_ok   <= 1'b0;
    end else begin
      r_rq_wptr <= w_rq_wptr_n;
      r_rq_rptr <= w_rq_rptr_n;
      r_rx_ok   <= (w_rq_wptr_n != w_rq_rptr_n);
    end
  end

  logic [1:0] w_err;
`ifdef GPMC_BRIDGE_ERR_EN
  logic r_ovf, r_udf, w_ovf_set, w_udf_set, w_clr_err;
  assign w_ovf_set = w_hpush && w_wq_full;
  assign w_udf_set = w_rd_load && !r_addr && w_rq_empty;
  assign w_clr_err = (r_state == READ) && w_noe_rise && !w_cs_rise && r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_clr_err) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_udf_set) r_udf <= 1'b1;
    end
  end
  assign w_err = {r_ovf, r_udf};
`else
  assign w_err = 2'b00;
`endif

  logic [15:0] w_status;
  assign w_status = {w_err, 6'(w_rq_cnt), 2'b00, 6'(PW'(DEPTH) - w_wq_cnt)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= 1'b0;
      r_rd_ne  <= 1'b0;
      r_wdata  <= '0;
      r_ad_out <= '0;
      r_ad_oe  <= 1'b0;
    end else begin
      r_ad_oe <= (w_next == READ);
      if (w_addr_lat) r_addr <= r_ad_s[0];
      if (r_state == WRITE && !w_nwe_s) r_wdata <= r_ad_s;
      if (w_rd_load) begin
        r_rd_ne <= !w_rq_empty;
        if (r_addr)          r_ad_out <= w_status;
        else if (w_rq_empty) r_ad_out <= '0;
        else                 r_ad_out <= r_rq_mem[r_rq_rptr[PW-2:0]];
      end
    end
  end

  assign ad_out     = r_ad_out;
  assign ad_oe      = r_ad_oe;
  assign wr_data    = r_wr_data;
  assign wr_valid   = r_wr_valid;
  assign rd_ready   = !w_rq_full;
  assign tx_data_ok = r_tx_ok;
  assign rx_data_ok = r_rx_ok;
endmodule
